// File: rtl/tdc_plot_distributer_if.sv
// Detector inputs and measurement/histogram outputs of the two-channel
// time-correlation front end.
interface tdc_plot_distributer_if;
  logic       pulse1;
  logic       pulse2;
  logic [1:0] START_signal;
  logic [1:0] END_signal;
  logic [6:0] INTERVAL;
  logic       data_arrived;
  logic [7:0] Addr;
  logic       Memory_add;

  modport slave (
    input  pulse1, pulse2,
    output START_signal, END_signal, INTERVAL, data_arrived, Addr, Memory_add
  );

  modport master (
    output pulse1, pulse2,
    input  START_signal, END_signal, INTERVAL, data_arrived, Addr, Memory_add
  );
endinterface

// File: rtl/tdc_plot_distributer.sv
// Two-channel TDC: measures the cycle interval between edges on opposite
// detector channels and turns each measurement into a histogram increment.
module tdc_plot_distributer (
  input  logic                  clk,
  input  logic                  rst,
  tdc_plot_distributer_if.slave bus
);

  typedef enum logic {IDLE, COUNT} state_t;

  logic [1:0] sync1, sync2;
  logic       sync1_d, sync2_d;
  logic       e1, e2;

  state_t     state;
  logic [6:0] cnt;
  logic [1:0] cur_start;
  logic [1:0] start_q, end_q;
  logic [6:0] interval_q;
  logic       data_arrived_q;
  logic [7:0] addr_q;
  logic       memory_add_q;

  logic       opp_edge, same_edge;

  // Two-flop synchronizers followed by registered rising-edge detectors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 2'b00;
      sync2   <= 2'b00;
      sync1_d <= 1'b0;
      sync2_d <= 1'b0;
      e1      <= 1'b0;
      e2      <= 1'b0;
    end else begin
      sync1   <= {sync1[0], bus.pulse1};
      sync2   <= {sync2[0], bus.pulse2};
      sync1_d <= sync1[1];
      sync2_d <= sync2[1];
      e1      <= sync1[1] & ~sync1_d;
      e2      <= sync2[1] & ~sync2_d;
    end
  end

  assign opp_edge  = (cur_start == 2'b01) ? e2 : e1;
  assign same_edge = (cur_start == 2'b01) ? e1 : e2;

  // cur_start tracks the open measurement; the START/END/INTERVAL outputs
  // only change when an event is emitted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 7'd0;
      cur_start      <= 2'b00;
      start_q        <= 2'b00;
      end_q          <= 2'b00;
      interval_q     <= 7'd0;
      data_arrived_q <= 1'b0;
    end else begin
      data_arrived_q <= 1'b0;
      case (state)
        IDLE: begin
          if (e1 && e2) begin
            start_q        <= 2'b11;
            end_q          <= 2'b11;
            interval_q     <= 7'd0;
            data_arrived_q <= 1'b1;
          end else if (e1 || e2) begin
            cur_start <= {e2, e1};
            cnt       <= 7'd0;
            state     <= COUNT;
          end
        end
        COUNT: begin
          if (opp_edge) begin
            start_q        <= cur_start;
            end_q          <= {e2, e1};
            interval_q     <= cnt + 7'd1;
            data_arrived_q <= 1'b1;
            state          <= IDLE;
          end else if (same_edge) begin
            cnt <= 7'd0;
          end else if (cnt == 7'd126) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Histogram address: channel order selects the half, coincidences go to bin 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= 8'h00;
      memory_add_q <= 1'b0;
    end else begin
      memory_add_q <= 1'b0;
      if (data_arrived_q) begin
        case ({start_q, end_q})
          4'b0110: begin
            addr_q       <= {1'b0, interval_q};
            memory_add_q <= 1'b1;
          end
          4'b1001: begin
            addr_q       <= {1'b1, interval_q};
            memory_add_q <= 1'b1;
          end
          4'b1111: begin
            addr_q       <= 8'h00;
            memory_add_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.START_signal = start_q;
  assign bus.END_signal   = end_q;
  assign bus.INTERVAL     = interval_q;
  assign bus.data_arrived = data_arrived_q;
  assign bus.Addr         = addr_q;
  assign bus.Memory_add   = memory_add_q;

endmodule

// File: tb/tb_tdc_plot_distributer.sv
// Directed bench for tdc_plot_distributer: a vector table of pulse timings
// plus hand-written timeout, reset-abort and reset-state sequences.
module tb_tdc_plot_distributer;

  logic clk;
  logic rst;
  tdc_plot_distributer_if bus();

  tdc_plot_distributer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         t1a, t1b, t2a, t2b, len;
    int         ev, mem;
    logic [1:0] st, en;
    logic [6:0] iv;
    logic [7:0] addr;
    int         da_t;
  } vec_t;

  vec_t vecs [9];

  int checks = 0;
  int errors = 0;

  int neg_count = 0;
  int ev_count  = 0;
  int mem_count = 0;
  int da_neg    = 0;
  int mem_neg   = 0;

  // Event monitor, sampled on the falling edge away from the active edge
  always @(negedge clk) begin
    neg_count <= neg_count + 1;
    if (!rst) begin
      if (bus.data_arrived) begin
        ev_count <= ev_count + 1;
        da_neg   <= neg_count + 1;
      end
      if (bus.Memory_add) begin
        mem_count <= mem_count + 1;
        mem_neg   <= neg_count + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic applyStimulus(input int t1a, input int t1b, input int t2a, input int t2b,
                               input int len, output int base);
    @(negedge clk); #1;
    base = neg_count;
    for (int t = 0; t < len; t++) begin
      if (t > 0) begin
        @(negedge clk); #1;
      end
      bus.pulse1 = (t == t1a) || (t == t1b);
      bus.pulse2 = (t == t2a) || (t == t2b);
    end
    @(negedge clk); #1;
    bus.pulse1 = 1'b0;
    bus.pulse2 = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk); #1;
    rst        = 1'b1;
    bus.pulse1 = 1'b0;
    bus.pulse2 = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic int allOutputs();
    return int'({bus.START_signal, bus.END_signal, bus.INTERVAL, bus.data_arrived,
                 bus.Addr, bus.Memory_add});
  endfunction

  initial begin
    int base, ev0, mem0;

    vecs[0] = '{0, -1, 5, -1, 25,    1, 1, 2'b01, 2'b10, 7'd5,   8'h05, 9};
    vecs[1] = '{12, -1, 0, -1, 32,   1, 1, 2'b10, 2'b01, 7'd12,  8'h8C, 16};
    vecs[2] = '{0, -1, 0, -1, 20,    1, 1, 2'b11, 2'b11, 7'd0,   8'h00, 4};
    vecs[3] = '{0, -1, 1, -1, 21,    1, 1, 2'b01, 2'b10, 7'd1,   8'h01, 5};
    vecs[4] = '{0, -1, 127, -1, 147, 1, 1, 2'b01, 2'b10, 7'd127, 8'h7F, 131};
    vecs[5] = '{0, -1, 128, -1, 170, 0, 0, 2'b00, 2'b00, 7'd0,   8'h00, -1};
    vecs[6] = '{2, -1, 0, 2, 22,     1, 0, 2'b10, 2'b11, 7'd2,   8'h00, 6};
    vecs[7] = '{0, 3, 7, -1, 27,     1, 1, 2'b01, 2'b10, 7'd4,   8'h04, 11};
    vecs[8] = '{0, 2, 1, 3, 23,      2, 2, 2'b01, 2'b10, 7'd1,   8'h01, -1};

    rst        = 1'b1;
    bus.pulse1 = 1'b0;
    bus.pulse2 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_state", allOutputs(), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      doReset();
      ev0  = ev_count;
      mem0 = mem_count;
      applyStimulus(vecs[i].t1a, vecs[i].t1b, vecs[i].t2a, vecs[i].t2b, vecs[i].len, base);
      checkOutput($sformatf("v%0d_events", i), ev_count - ev0, vecs[i].ev);
      checkOutput($sformatf("v%0d_mem_adds", i), mem_count - mem0, vecs[i].mem);
      checkOutput($sformatf("v%0d_START", i), int'(bus.START_signal), int'(vecs[i].st));
      checkOutput($sformatf("v%0d_END", i), int'(bus.END_signal), int'(vecs[i].en));
      checkOutput($sformatf("v%0d_INTERVAL", i), int'(bus.INTERVAL), int'(vecs[i].iv));
      checkOutput($sformatf("v%0d_Addr", i), int'(bus.Addr), int'(vecs[i].addr));
      if (vecs[i].da_t >= 0) begin
        checkOutput($sformatf("v%0d_da_latency", i), da_neg - base, vecs[i].da_t);
        if (vecs[i].mem > 0)
          checkOutput($sformatf("v%0d_mem_latency", i), mem_neg - da_neg, 1);
      end
    end

    // Long wait with only pulse1, then a normal measurement without reset
    $display("[TB] timeout sequence");
    doReset();
    ev0  = ev_count;
    mem0 = mem_count;
    applyStimulus(0, -1, -1, -1, 200, base);
    checkOutput("timeout_events", ev_count - ev0, 0);
    checkOutput("timeout_mem_adds", mem_count - mem0, 0);
    applyStimulus(0, -1, 2, -1, 22, base);
    checkOutput("after_timeout_events", ev_count - ev0, 1);
    checkOutput("after_timeout_mem_adds", mem_count - mem0, 1);
    checkOutput("after_timeout_INTERVAL", int'(bus.INTERVAL), 2);
    checkOutput("after_timeout_Addr", int'(bus.Addr), 8'h02);

    // Reset in the middle of a measurement
    $display("[TB] reset-abort sequence");
    doReset();
    applyStimulus(0, -1, 5, -1, 10, base);
    checkOutput("pre_abort_Addr", int'(bus.Addr), 8'h05);
    applyStimulus(0, -1, -1, -1, 3, base);
    ev0  = ev_count;
    mem0 = mem_count;
    rst        = 1'b1;
    bus.pulse2 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      bus.pulse2 = 1'b0;
      checkOutput($sformatf("in_reset_outputs_%0d", c), allOutputs(), 0);
    end
    rst = 1'b0;
    applyStimulus(-1, -1, 0, -1, 40, base);
    checkOutput("abort_events", ev_count - ev0, 0);
    checkOutput("abort_mem_adds", mem_count - mem0, 0);
    checkOutput("abort_outputs", allOutputs(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
